// File: rtl/cve2_irq_ctrl.sv
// Interrupt controller for the cve2 core: machine timer, software interrupt,
// external level source and 16 fast sources with a small word register bus.
module cve2_irq_ctrl #(
  parameter int unsigned TimerPrescale = 1,
  parameter logic [15:0] FastEdgeMask  = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_gnt_o,
  output logic        reg_rvalid_o,
  output logic [31:0] reg_rdata_o,
  output logic        reg_err_o,
  input  logic        ext_src_i,
  input  logic [15:0] fast_src_i,
  output logic        irq_software_o,
  output logic        irq_timer_o,
  output logic        irq_external_o,
  output logic [15:0] irq_fast_o
);

  localparam logic [7:0] PreLast = 8'(TimerPrescale - 1);

  logic        msip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [7:0]  pre_cnt;
  logic [15:0] fast_pend;
  logic [15:0] fast_en;
  logic [15:0] fast_prev;

  logic        addr_err;
  logic        access_ok;
  logic        wr;
  logic [2:0]  word;
  logic        tick;
  logic [15:0] w1c;
  logic [15:0] fast_rise;
  logic [15:0] fast_pend_next;
  logic [7:0]  cause;
  logic [31:0] read_data;

  // Misaligned accesses and writes to the read-only CAUSE word are rejected
  assign word      = reg_addr_i[4:2];
  assign addr_err  = (reg_addr_i[1:0] != 2'd0) || (reg_we_i && word == 3'd7);
  assign access_ok = reg_req_i && !addr_err;
  assign wr        = access_ok && reg_we_i;
  assign reg_gnt_o = reg_req_i;

  assign tick      = (pre_cnt == PreLast);
  assign w1c       = (wr && word == 3'd5) ? reg_wdata_i[15:0] : 16'd0;
  assign fast_rise = fast_src_i & ~fast_prev;

  // A fresh edge beats a same-cycle clear; level sources ignore clears entirely
  assign fast_pend_next = (FastEdgeMask & ((fast_pend & ~w1c) | fast_rise))
                        | (~FastEdgeMask & fast_src_i);

  always_comb begin
    cause = 8'd0;
    if (irq_external_o) begin
      cause = 8'h8B;
    end else if (irq_software_o) begin
      cause = 8'h83;
    end else if (irq_timer_o) begin
      cause = 8'h87;
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (irq_fast_o[i]) begin
          cause = 8'h90 + 8'(i);
        end
      end
    end
  end

  always_comb begin
    read_data = 32'd0;
    case (word)
      3'd0:    read_data = {31'd0, msip};
      3'd1:    read_data = mtime[31:0];
      3'd2:    read_data = mtime[63:32];
      3'd3:    read_data = mtimecmp[31:0];
      3'd4:    read_data = mtimecmp[63:32];
      3'd5:    read_data = {16'd0, fast_pend};
      3'd6:    read_data = {16'd0, fast_en};
      default: read_data = {24'd0, cause};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msip      <= 1'b0;
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      pre_cnt   <= 8'd0;
      fast_pend <= 16'd0;
      fast_en   <= 16'd0;
      fast_prev <= 16'd0;
    end else begin
      pre_cnt   <= tick ? 8'd0 : pre_cnt + 8'd1;
      fast_prev <= fast_src_i;
      fast_pend <= fast_pend_next;
      // A bus write to either mtime half swallows that cycle's increment
      if (wr && word == 3'd1) begin
        mtime[31:0] <= reg_wdata_i;
      end else if (wr && word == 3'd2) begin
        mtime[63:32] <= reg_wdata_i;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (wr && word == 3'd0) msip <= reg_wdata_i[0];
      if (wr && word == 3'd3) mtimecmp[31:0] <= reg_wdata_i;
      if (wr && word == 3'd4) mtimecmp[63:32] <= reg_wdata_i;
      if (wr && word == 3'd6) fast_en <= reg_wdata_i[15:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_rvalid_o   <= 1'b0;
      reg_err_o      <= 1'b0;
      reg_rdata_o    <= 32'd0;
      irq_software_o <= 1'b0;
      irq_timer_o    <= 1'b0;
      irq_external_o <= 1'b0;
      irq_fast_o     <= 16'd0;
    end else begin
      reg_rvalid_o   <= reg_req_i;
      reg_err_o      <= reg_req_i && addr_err;
      reg_rdata_o    <= (access_ok && !reg_we_i) ? read_data : 32'd0;
      irq_software_o <= msip;
      irq_timer_o    <= (mtime >= mtimecmp);
      irq_external_o <= ext_src_i;
      irq_fast_o     <= fast_pend & fast_en;
    end
  end

endmodule

// File: tb/tb_cve2_irq_ctrl.sv
// Directed bench for cve2_irq_ctrl: two instances (prescale 1 / all-edge and
// prescale 4 / mixed level) share stimulus and are checked against a cycle model.
module tb_cve2_irq_ctrl;

  localparam int unsigned PreA  = 1;
  localparam int unsigned PreB  = 4;
  localparam logic [15:0] MaskA = 16'hFFFF;
  localparam logic [15:0] MaskB = 16'hFF0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ext;
  logic [15:0] fsrc;

  logic        gnt_a, rvalid_a, err_a, sw_a, tm_a, ex_a;
  logic [31:0] rdata_a;
  logic [15:0] fast_a;
  logic        gnt_b, rvalid_b, err_b, sw_b, tm_b, ex_b;
  logic [31:0] rdata_b;
  logic [15:0] fast_b;

  int vectors    = 0;
  int miscompares = 0;
  logic check_en;

  always #5 clk = ~clk;

  cve2_irq_ctrl #(.TimerPrescale(PreA), .FastEdgeMask(MaskA)) dut_a (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_gnt_o(gnt_a), .reg_rvalid_o(rvalid_a),
    .reg_rdata_o(rdata_a), .reg_err_o(err_a), .ext_src_i(ext), .fast_src_i(fsrc),
    .irq_software_o(sw_a), .irq_timer_o(tm_a), .irq_external_o(ex_a),
    .irq_fast_o(fast_a)
  );

  cve2_irq_ctrl #(.TimerPrescale(PreB), .FastEdgeMask(MaskB)) dut_b (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_gnt_o(gnt_b), .reg_rvalid_o(rvalid_b),
    .reg_rdata_o(rdata_b), .reg_err_o(err_b), .ext_src_i(ext), .fast_src_i(fsrc),
    .irq_software_o(sw_b), .irq_timer_o(tm_b), .irq_external_o(ex_b),
    .irq_fast_o(fast_b)
  );

  // Model state, one slot per instance
  logic [63:0] m_mtime[2];
  logic [63:0] m_cmp[2];
  logic        m_msip[2];
  logic [15:0] m_pend[2];
  logic [15:0] m_en[2];
  logic [15:0] m_prev[2];
  int unsigned m_cyc[2];
  logic        e_sw[2], e_tm[2], e_ex[2], e_rvalid[2], e_err[2];
  logic [15:0] e_fast[2];
  logic [31:0] e_rdata[2];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] causeOf(input int i);
    logic [31:0] c;
    c = 32'd0;
    if (e_ex[i]) c = 32'h8B;
    else if (e_sw[i]) c = 32'h83;
    else if (e_tm[i]) c = 32'h87;
    else begin
      for (int j = 0; j < 16; j++) begin
        if (e_fast[i][j] && c == 32'd0) c = 32'h90 + j;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] readReg(input int i, input logic [4:0] a);
    case (a)
      5'h00:   return {31'd0, m_msip[i]};
      5'h04:   return m_mtime[i][31:0];
      5'h08:   return m_mtime[i][63:32];
      5'h0C:   return m_cmp[i][31:0];
      5'h10:   return m_cmp[i][63:32];
      5'h14:   return {16'd0, m_pend[i]};
      5'h18:   return {16'd0, m_en[i]};
      5'h1C:   return causeOf(i);
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      logic        bad;
      logic [31:0] rv;
      logic [63:0] nt;
      logic [15:0] np;
      logic [15:0] clr;
      logic [15:0] mk;
      int unsigned pr;
      mk = (i == 0) ? MaskA : MaskB;
      pr = (i == 0) ? PreA : PreB;
      if (rst) begin
        m_mtime[i] = 64'd0; m_cmp[i] = '1; m_msip[i] = 1'b0;
        m_pend[i] = 16'd0; m_en[i] = 16'd0; m_prev[i] = 16'd0; m_cyc[i] = 0;
        e_sw[i] = 1'b0; e_tm[i] = 1'b0; e_ex[i] = 1'b0; e_fast[i] = 16'd0;
        e_rvalid[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = 32'd0;
      end else begin
        bad = (addr[1:0] != 2'd0) || (we && addr == 5'h1C);
        rv  = readReg(i, addr);
        nt  = (((m_cyc[i] + 1) % pr) == 0) ? m_mtime[i] + 64'd1 : m_mtime[i];
        m_cyc[i]++;
        clr = (req && we && !bad && addr == 5'h14) ? wdata[15:0] : 16'd0;
        for (int b = 0; b < 16; b++) begin
          if (mk[b]) np[b] = (fsrc[b] && !m_prev[i][b]) ? 1'b1 : (m_pend[i][b] && !clr[b]);
          else np[b] = fsrc[b];
        end
        e_rvalid[i] = req;
        e_err[i]    = req && bad;
        e_rdata[i]  = (req && !we && !bad) ? rv : 32'd0;
        e_tm[i]     = (m_mtime[i] >= m_cmp[i]);
        e_sw[i]     = m_msip[i];
        e_ex[i]     = ext;
        e_fast[i]   = m_pend[i] & m_en[i];
        if (req && we && !bad) begin
          case (addr)
            5'h00: m_msip[i] = wdata[0];
            5'h04: nt = {m_mtime[i][63:32], wdata};
            5'h08: nt = {wdata, m_mtime[i][31:0]};
            5'h0C: m_cmp[i][31:0] = wdata;
            5'h10: m_cmp[i][63:32] = wdata;
            5'h18: m_en[i] = wdata[15:0];
            default: ;
          endcase
        end
        m_mtime[i] = nt;
        m_pend[i]  = np;
        m_prev[i]  = fsrc;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Per-cycle comparison of every registered output of both instances
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("a irq_software", sw_a, e_sw[0]);
        checkOutput("a irq_timer", tm_a, e_tm[0]);
        checkOutput("a irq_external", ex_a, e_ex[0]);
        checkOutput("a irq_fast", fast_a, e_fast[0]);
        checkOutput("a rvalid", rvalid_a, e_rvalid[0]);
        checkOutput("a err", err_a, e_err[0]);
        checkOutput("a rdata", rdata_a, e_rdata[0]);
        checkOutput("b irq_software", sw_b, e_sw[1]);
        checkOutput("b irq_timer", tm_b, e_tm[1]);
        checkOutput("b irq_external", ex_b, e_ex[1]);
        checkOutput("b irq_fast", fast_b, e_fast[1]);
        checkOutput("b rvalid", rvalid_b, e_rvalid[1]);
        checkOutput("b err", err_b, e_err[1]);
        checkOutput("b rdata", rdata_b, e_rdata[1]);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d;
    #1;
    if (r) begin
      checkOutput("a gnt", gnt_a, 1'b1);
      checkOutput("b gnt", gnt_b, 1'b1);
    end
  endtask

  // One bus transaction; returns at the negedge where the response is visible
  task automatic busAccess(input logic w, input logic [4:0] a, input logic [31:0] d,
                           output logic [31:0] rd_a, output logic [31:0] rd_b,
                           output logic er_a);
    applyStimulus(1'b1, w, a, d);
    @(negedge clk);
    checkOutput("a rvalid after grant", rvalid_a, 1'b1);
    rd_a = rdata_a;
    rd_b = rdata_b;
    er_a = err_a;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        ea;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
    ext = 1'b0; fsrc = 16'd0; check_en = 1'b0;
    idle(2);
    check_en = 1'b1;
    checkOutput("reset irq_timer", tm_a, 1'b0);
    checkOutput("reset irq_fast", fast_a, 16'd0);
    checkOutput("reset rvalid", rvalid_a, 1'b0);
    checkOutput("reset rdata", rdata_a, 32'd0);
    rst = 1'b0;

    busAccess(1'b0, 5'h0C, 32'd0, ra, rb, ea);
    checkOutput("reset mtimecmp_lo", ra, 32'hFFFF_FFFF);
    busAccess(1'b0, 5'h00, 32'd0, ra, rb, ea);
    checkOutput("reset msip", ra, 32'd0);

    // Timer compare at 10 with prescale 1
    busAccess(1'b1, 5'h10, 32'd0, ra, rb, ea);
    busAccess(1'b1, 5'h0C, 32'd10, ra, rb, ea);
    busAccess(1'b1, 5'h04, 32'd0, ra, rb, ea);
    idle(10);
    checkOutput("timer low at mtime 10", tm_a, 1'b0);
    idle(1);
    checkOutput("timer high after mtime 10", tm_a, 1'b1);
    busAccess(1'b1, 5'h0C, 32'hFFFF_FFFF, ra, rb, ea);
    busAccess(1'b1, 5'h10, 32'hFFFF_FFFF, ra, rb, ea);
    idle(1);
    checkOutput("timer cleared", tm_a, 1'b0);

    // Carry from mtime low into high, and write priority over increment
    busAccess(1'b1, 5'h08, 32'd0, ra, rb, ea);
    busAccess(1'b1, 5'h04, 32'hFFFF_FFFF, ra, rb, ea);
    idle(5);
    busAccess(1'b0, 5'h08, 32'd0, ra, rb, ea);
    checkOutput("a mtime_hi carry", ra, 32'd1);
    checkOutput("b mtime_hi carry", rb, 32'd1);
    busAccess(1'b1, 5'h04, 32'd5, ra, rb, ea);
    busAccess(1'b0, 5'h04, 32'd0, ra, rb, ea);
    checkOutput("a mtime_lo write wins", ra, 32'd6);

    // Fast pulse on source 0, then clear
    busAccess(1'b1, 5'h18, 32'h0001, ra, rb, ea);
    @(negedge clk); fsrc = 16'h0001;
    @(negedge clk); fsrc = 16'h0000;
    idle(1);
    checkOutput("fast0 irq set", fast_a, 16'h0001);
    idle(3);
    checkOutput("fast0 irq held", fast_a, 16'h0001);
    busAccess(1'b0, 5'h14, 32'd0, ra, rb, ea);
    checkOutput("fast_pend after pulse", ra, 32'h0001);
    busAccess(1'b1, 5'h14, 32'h0001, ra, rb, ea);
    idle(1);
    checkOutput("fast0 irq cleared", fast_a, 16'h0000);

    // Edge on bit 3 in the same cycle as its clear
    applyStimulus(1'b1, 1'b1, 5'h14, 32'h0008);
    fsrc = 16'h0008;
    @(negedge clk);
    req = 1'b0; we = 1'b0; fsrc = 16'h0000;
    busAccess(1'b0, 5'h14, 32'd0, ra, rb, ea);
    checkOutput("edge beats w1c", ra, 32'h0008);
    busAccess(1'b1, 5'h14, 32'h0008, ra, rb, ea);

    // Cause priority
    busAccess(1'b1, 5'h18, 32'hFFFF, ra, rb, ea);
    ext = 1'b1; fsrc = 16'h0030;
    idle(3);
    busAccess(1'b0, 5'h1C, 32'd0, ra, rb, ea);
    checkOutput("a cause external", ra, 32'h8B);
    checkOutput("b cause external", rb, 32'h8B);
    ext = 1'b0;
    idle(3);
    busAccess(1'b0, 5'h1C, 32'd0, ra, rb, ea);
    checkOutput("a cause fast4", ra, 32'h94);
    checkOutput("b cause fast4", rb, 32'h94);
    busAccess(1'b1, 5'h00, 32'd1, ra, rb, ea);
    idle(2);
    checkOutput("irq_software", sw_a, 1'b1);
    busAccess(1'b0, 5'h1C, 32'd0, ra, rb, ea);
    checkOutput("cause software", ra, 32'h83);
    busAccess(1'b1, 5'h00, 32'd0, ra, rb, ea);
    fsrc = 16'h0000;
    busAccess(1'b1, 5'h14, 32'h0030, ra, rb, ea);

    // Error responses; 0x20 is outside the 5-bit byte address, so out-of-map
    // decoding is covered through misalignment and the CAUSE write
    busAccess(1'b1, 5'h1C, 32'h1234, ra, rb, ea);
    checkOutput("cause write err", ea, 1'b1);
    checkOutput("cause write rdata", ra, 32'd0);
    busAccess(1'b0, 5'h06, 32'd0, ra, rb, ea);
    checkOutput("misaligned read err", ea, 1'b1);
    checkOutput("misaligned read rdata", ra, 32'd0);
    busAccess(1'b1, 5'h1A, 32'd0, ra, rb, ea);
    checkOutput("misaligned write err", ea, 1'b1);
    busAccess(1'b0, 5'h18, 32'd0, ra, rb, ea);
    checkOutput("fast_en unchanged", ra, 32'hFFFF);
    checkOutput("good read no err", ea, 1'b0);
    idle(2);
    busAccess(1'b0, 5'h1C, 32'd0, ra, rb, ea);
    checkOutput("cause idle", ra, 32'd0);

    // Reset during an access, with a source held high across it
    @(negedge clk); fsrc = 16'h0002;
    idle(2);
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 5'h14;
    @(negedge clk);
    req = 1'b0;
    checkOutput("reset drops response", rvalid_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    busAccess(1'b0, 5'h14, 32'd0, ra, rb, ea);
    checkOutput("held source edge after reset", ra, 32'h0002);
    busAccess(1'b0, 5'h10, 32'd0, ra, rb, ea);
    checkOutput("mtimecmp_hi after reset", ra, 32'hFFFF_FFFF);
    busAccess(1'b0, 5'h18, 32'd0, ra, rb, ea);
    checkOutput("fast_en after reset", ra, 32'd0);
    fsrc = 16'h0000;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
